// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer and its datapath.
// Optional prescaler is enabled with COUNTER_SEQ_PRESCALE_EN.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int DEFAULT_WIDTH      = 4;
    localparam int DEFAULT_PRESCALE_W = 4;

endpackage

// File: rtl/counter_bit_cell.sv
// One counter bit: half-adder sum into a flip-flop, carry passed upward.
// Synchronous clear wins over the carry-in.
module counter_bit_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic cin_i,
    output logic q_o,
    output logic cout_o
);

    logic q_q;
    logic q_d;

    assign q_d    = clear_i ? 1'b0 : (q_q ^ cin_i);
    assign q_o    = q_q;
    assign cout_o = q_q & cin_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/counter_datapath.sv
// Ripple-carry incrementing register built from per-bit adder/flop cells.
// inc_en feeds the carry chain; clear zeroes every bit.
module counter_datapath #(
    parameter int WIDTH = counter_seq_pkg::DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_en,
    input  logic             clear,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH:0] carry;
    logic           unused_carry;

    assign carry[0]     = inc_en;
    assign unused_carry = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        counter_bit_cell u_cell (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear),
            .cin_i   (carry[i]),
            .q_o     (value[i]),
            .cout_o  (carry[i+1])
        );
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run controller: one-shot / auto-reload sequencing of counter_datapath.
// Optional enable divider compiled in with COUNTER_SEQ_PRESCALE_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      terminal,
`ifdef COUNTER_SEQ_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic                  busy,
    output logic                  tick,
    output logic                  done,
    output logic [WIDTH-1:0]      count
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] terminal_q, terminal_d;
    logic             reload_q, reload_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             inc_en;
    logic             clear;
    logic             enable;

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] div_q, div_d;

    assign enable = (div_q == prescale_q);

    // Divider restarts at accept so the first enable lands prescale_q+1 clocks later.
    always_comb begin
        prescale_d = prescale_q;
        div_d      = div_q;
        if (state_q == IDLE && start) begin
            prescale_d = prescale;
            div_d      = '0;
        end else if (state_q == RUN) begin
            div_d = enable ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale_q <= '0;
            div_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`else
    assign enable = 1'b1;
`endif

    counter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_en (inc_en),
        .clear  (clear),
        .value  (count)
    );

    always_comb begin
        state_d    = state_q;
        terminal_d = terminal_q;
        reload_d   = reload_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        inc_en     = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    terminal_d = terminal;
                    reload_d   = auto_reload;
                    clear      = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // stop outranks a coincident terminal match
                if (stop) begin
                    state_d = IDLE;
                end else if (enable) begin
                    if (count != terminal_q) begin
                        inc_en = 1'b1;
                    end else if (reload_q) begin
                        clear  = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        tick_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            terminal_q <= '0;
            reload_q   <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            terminal_q <= terminal_d;
            reload_q   <= reload_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign tick = tick_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer (WIDTH=4).
// Prescaler scenario runs only when COUNTER_SEQ_PRESCALE_EN is defined.
module tb_counter_sequencer;

    localparam int WIDTH      = 4;
    localparam int PRESCALE_W = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] terminal;
`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic             busy;
    logic             tick;
    logic             done;
    logic [WIDTH-1:0] count;

    int checks;
    int errors;

    counter_sequencer #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .terminal    (terminal),
`ifdef COUNTER_SEQ_PRESCALE_EN
        .prescale    (prescale),
`endif
        .busy        (busy),
        .tick        (tick),
        .done        (done),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [WIDTH-1:0] t, input logic ar);
        terminal    = t;
        auto_reload = ar;
        start       = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #2;
        checks++;
        if ({busy, tick, done, count} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b tick=%b done=%b count=%0d want all 0",
                     busy, tick, done, count);
        end
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b count=%0d want 0 0", busy, count);
        end
    endtask

    task automatic test_oneshot();
        launch(4'd3, 1'b0);
        checks++;
        if (busy !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL oneshot_accept got busy=%b count=%0d want 1 0", busy, count);
        end
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (count !== 4'(e) || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_count edge=%0d got count=%0d tick=%b done=%b busy=%b want %0d 0 0 1",
                         e, count, tick, done, busy, e);
            end
        end
        step();
        checks++;
        if (tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 4'd3) begin
            errors++;
            $display("FAIL oneshot_done got tick=%b done=%b busy=%b count=%0d want 1 1 0 3",
                     tick, done, busy, count);
        end
        step();
        checks++;
        if (tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || count !== 4'd3) begin
            errors++;
            $display("FAIL oneshot_after got tick=%b done=%b busy=%b count=%0d want 0 0 0 3",
                     tick, done, busy, count);
        end
        launch(4'd3, 1'b0);
        checks++;
        if (busy !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL oneshot_restart got busy=%b count=%0d want 1 0", busy, count);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 4'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_stop got busy=%b count=%0d tick=%b want 0 0 0",
                     busy, count, tick);
        end
    endtask

    task automatic test_reload();
        launch(4'd2, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (count !== 4'(i % 3) || tick !== (i % 3 == 0) || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL reload_seq cyc=%0d got count=%0d tick=%b done=%b busy=%b want %0d %b 0 1",
                         i, count, tick, done, busy, i % 3, (i % 3 == 0));
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 4'd1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reload_stop got busy=%b count=%0d tick=%b want 0 1 0",
                     busy, count, tick);
        end
    endtask

    task automatic test_terminal_max();
        launch(4'd15, 1'b0);
        for (int e = 1; e <= 15; e++) begin
            step();
            checks++;
            if (count !== 4'(e) || done !== 1'b0) begin
                errors++;
                $display("FAIL tmax_count edge=%0d got count=%0d done=%b want %0d 0",
                         e, count, done, e);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || tick !== 1'b1 || count !== 4'd15 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmax_done got done=%b tick=%b count=%0d busy=%b want 1 1 15 0",
                     done, tick, count, busy);
        end
        step();
    endtask

    task automatic test_terminal_zero();
        launch(4'd0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (tick !== 1'b1 || count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL tzero_periodic cyc=%0d got tick=%b count=%0d busy=%b done=%b want 1 0 1 0",
                         i, tick, count, busy, done);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        launch(4'd0, 1'b0);
        step();
        checks++;
        if (done !== 1'b1 || tick !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tzero_oneshot got done=%b tick=%b busy=%b want 1 1 0", done, tick, busy);
        end
        step();
    endtask

    task automatic test_stop_at_terminal();
        launch(4'd2, 1'b1);
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (tick !== 1'b0 || busy !== 1'b0 || count !== 4'd2) begin
            errors++;
            $display("FAIL stop_terminal got tick=%b busy=%b count=%0d want 0 0 2", tick, busy, count);
        end
        step();
        checks++;
        if (tick !== 1'b0 || busy !== 1'b0 || count !== 4'd2) begin
            errors++;
            $display("FAIL stop_idle_hold got tick=%b busy=%b count=%0d want 0 0 2", tick, busy, count);
        end
    endtask

    task automatic test_reset_midrun();
        launch(4'd9, 1'b0);
        for (int e = 1; e <= 5; e++) step();
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("FAIL midrun_pre got count=%0d want 5", count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, tick, done, count} !== 7'b0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b tick=%b done=%b count=%0d want all 0",
                     busy, tick, done, count);
        end
        #2;
        reset = 1'b1;
        launch(4'd9, 1'b0);
        checks++;
        if (busy !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL midrun_restart got busy=%b count=%0d want 1 0", busy, count);
        end
        step();
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL midrun_inc got count=%0d want 1", count);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

`ifdef COUNTER_SEQ_PRESCALE_EN
    task automatic test_prescale();
        logic [WIDTH-1:0] exp_cnt [6];
        exp_cnt = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        prescale = 4'd2;
        launch(4'd1, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++;
            if (count !== exp_cnt[e-1] || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL prescale_count edge=%0d got count=%0d done=%b busy=%b want %0d 0 1",
                         e, count, done, busy, exp_cnt[e-1]);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || tick !== 1'b1 || count !== 4'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL prescale_done got done=%b tick=%b count=%0d busy=%b want 1 1 1 0",
                     done, tick, count, busy);
        end
        step();
        prescale = 4'd0;
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        start       = 1'b0;
        stop        = 1'b0;
        auto_reload = 1'b0;
        terminal    = '0;
`ifdef COUNTER_SEQ_PRESCALE_EN
        prescale    = '0;
`endif
        test_reset();
        test_oneshot();
        test_reload();
        test_terminal_max();
        test_terminal_zero();
        test_stop_at_terminal();
        test_reset_midrun();
`ifdef COUNTER_SEQ_PRESCALE_EN
        test_prescale();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
